mdu: RTL and testbench
======================

Name: mdu

Overview:
Multi-cycle multiply/divide unit for the pipelined MIPS core. It sits in the EX stage next to the ALU and owns the architectural HI/LO registers. It executes mult/multu/div/divu with a fixed latency and busy handshake, services mthi/mtlo writes, and returns HI or LO for mfhi/mflo. Hazard control stalls the decode stage while the unit is busy.

Parameters:
MULT_CYCLES, 5, cycles busy is held after a mult/multu start (>=1)
DIV_CYCLES, 10, cycles busy is held after a div/divu start (>=1)

Ports:
clk  input  1  sole clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
operand1  input  32  rs value (dividend / multiplicand / mthi-mtlo source)
operand2  input  32  rt value (divisor / multiplier)
operation  input  4  MDUOP_* code from shared macros
start  input  1  one-cycle pulse launching the operation on `operation` (EX stage, not stalled/flushed)
busy  output  1  high while a mult/div is in flight
result  output  32  HI for MDUOP_MFHI, LO for MDUOP_MFLO, else 0 (combinational)

Behaviour:
- Reset (async, active-high): HI=0, LO=0, busy=0, counter=0, state=IDLE, pending regs=0; result therefore 0. Reset mid-operation aborts it with no HI/LO update.
- States: IDLE, BUSY. The counter width covers max(MULT_CYCLES, DIV_CYCLES).
- IDLE with start=1, op MULT/MULTU/DIV/DIVU: compute and latch pending {hi,lo} from the operands sampled that edge. Load counter with the op's cycle count and go to BUSY. busy rises the next cycle.
- BUSY: decrement the counter each cycle. When the counter reaches 1, on that edge: commit pending to HI/LO, go to IDLE, and drop busy. busy is high for exactly N cycles after the start edge.
- Arithmetic:
  - MULT: {HI,LO} = signed 64-bit product.
  - MULTU: {HI,LO} = unsigned 64-bit product.
  - DIV: LO = signed quotient truncated toward zero, HI = remainder with the dividend's sign. 0x80000000 / -1 gives LO=0x80000000, HI=0.
  - DIVU: unsigned quotient and remainder.
- Divide by zero (DIV or DIVU with operand2=0): the unit still goes busy for DIV_CYCLES, but HI/LO are left unchanged at commit.
- MTHI/MTLO with start=1 in IDLE: HI or LO = operand1 on that edge. busy stays 0 and there is no latency.
- MFHI/MFLO: combinational read of the current registers, no start required. During BUSY the read returns the old HI/LO; the pipeline must stall any MDU instruction in D while start|busy.
- start while BUSY: ignored for all ops (protocol violation; the in-flight op completes unaffected).
- Undefined operation codes: no state change; result=0.

Decomposition:
- Shared macros file gains MDUOP_NONE, MDUOP_MULT, MDUOP_MULTU, MDUOP_DIV, MDUOP_DIVU, MDUOP_MTHI, MDUOP_MTLO, MDUOP_MFHI, MDUOP_MFLO as 4-bit codes.
- No sub-module needed. The product and quotient use behavioural operators inside mdu; the FSM and counter live in the same module.

Test Plan:
- MULT, op1=0xFFFFFFFE(-2), op2=3, start pulse -> busy high for exactly 5 cycles; afterwards MFHI=0xFFFFFFFF, MFLO=0xFFFFFFFA.
- DIVU, op1=100, op2=7 -> busy high for 10 cycles; HI=2, LO=14. DIV, op1=-7, op2=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- MTHI op1=0x12345678 then MTLO op1=0x9ABCDEF0 -> busy never rises; MFHI/MFLO read those values on the next cycle.
- DIV with op2=0 after HI=5, LO=6 -> busy 10 cycles; HI=5, LO=6 unchanged. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MULTU 0xFFFFFFFF*0xFFFFFFFF, then a second start (MTHI 0x1) at cycle 2 of BUSY -> second start ignored; HI=0xFFFFFFFE, LO=0x00000001.
- Start DIVU 100/7 with HI=LO=0, assert reset at cycle 4 -> busy=0 immediately (asynchronous); HI=LO=0. A new MULT 3*4 then completes normally with LO=12.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes,
// FSM state encoding and a small operation-class helper.
package mdu_pkg;

    localparam logic [3:0] MDUOP_NONE  = 4'd0;
    localparam logic [3:0] MDUOP_MULT  = 4'd1;
    localparam logic [3:0] MDUOP_MULTU = 4'd2;
    localparam logic [3:0] MDUOP_DIV   = 4'd3;
    localparam logic [3:0] MDUOP_DIVU  = 4'd4;
    localparam logic [3:0] MDUOP_MTHI  = 4'd5;
    localparam logic [3:0] MDUOP_MTLO  = 4'd6;
    localparam logic [3:0] MDUOP_MFHI  = 4'd7;
    localparam logic [3:0] MDUOP_MFLO  = 4'd8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    // True for the operations that occupy the unit for several cycles.
    function automatic logic is_long_op(input logic [3:0] op);
        logic long_s;
        case (op)
            MDUOP_MULT, MDUOP_MULTU, MDUOP_DIV, MDUOP_DIVU: long_s = 1'b1;
            default:                                        long_s = 1'b0;
        endcase
        return long_s;
    endfunction

endpackage

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// Results are computed when the operation is launched, held in pending
// registers, and committed to HI/LO when the fixed latency expires.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    input  logic [3:0]  operation,
    input  logic        start,
    output logic        busy,
    output logic [31:0] result
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

    mdu_state_e        state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic              busy_r, busy_s;
    logic [31:0]       hi_r, hi_s;
    logic [31:0]       lo_r, lo_s;
    logic [31:0]       pend_hi_r, pend_hi_s;
    logic [31:0]       pend_lo_r, pend_lo_s;
    logic              pend_we_r, pend_we_s;

    logic              mul_signed_s;
    logic [63:0]       mul_a_s;
    logic [63:0]       mul_b_s;
    logic [63:0]       product_s;
    logic              div_signed_s;
    logic              div_by_zero_s;
    logic              dividend_neg_s;
    logic              divisor_neg_s;
    logic [31:0]       dividend_mag_s;
    logic [31:0]       divisor_mag_s;
    logic [31:0]       divisor_safe_s;
    logic [31:0]       quot_mag_s;
    logic [31:0]       rem_mag_s;
    logic [31:0]       quot_s;
    logic [31:0]       rem_s;

    // Product and quotient/remainder of the current operands.
    // Division works on magnitudes so 0x80000000 / -1 wraps to 0x80000000
    // instead of hitting signed overflow; a zero divisor is replaced by 1
    // to keep the datapath defined (its result is never committed).
    always_comb begin
        mul_signed_s   = (operation == MDUOP_MULT);
        mul_a_s        = mul_signed_s ? {{32{operand1[31]}}, operand1} : {32'd0, operand1};
        mul_b_s        = mul_signed_s ? {{32{operand2[31]}}, operand2} : {32'd0, operand2};
        product_s      = mul_a_s * mul_b_s;

        div_signed_s   = (operation == MDUOP_DIV);
        div_by_zero_s  = (operand2 == 32'd0);
        dividend_neg_s = div_signed_s & operand1[31];
        divisor_neg_s  = div_signed_s & operand2[31];
        dividend_mag_s = dividend_neg_s ? (32'd0 - operand1) : operand1;
        divisor_mag_s  = divisor_neg_s ? (32'd0 - operand2) : operand2;
        divisor_safe_s = div_by_zero_s ? 32'd1 : divisor_mag_s;
        quot_mag_s     = dividend_mag_s / divisor_safe_s;
        rem_mag_s      = dividend_mag_s % divisor_safe_s;
        quot_s         = (dividend_neg_s ^ divisor_neg_s) ? (32'd0 - quot_mag_s) : quot_mag_s;
        rem_s          = dividend_neg_s ? (32'd0 - rem_mag_s) : rem_mag_s;
    end

    // Next-state logic: launch, countdown, commit and HI/LO moves.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        busy_s    = busy_r;
        hi_s      = hi_r;
        lo_s      = lo_r;
        pend_hi_s = pend_hi_r;
        pend_lo_s = pend_lo_r;
        pend_we_s = pend_we_r;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    case (operation)
                        MDUOP_MULT, MDUOP_MULTU: begin
                            pend_hi_s = product_s[63:32];
                            pend_lo_s = product_s[31:0];
                            pend_we_s = 1'b1;
                            cnt_s     = MULT_LOAD;
                            state_s   = ST_BUSY;
                            busy_s    = 1'b1;
                        end
                        MDUOP_DIV, MDUOP_DIVU: begin
                            pend_hi_s = rem_s;
                            pend_lo_s = quot_s;
                            pend_we_s = ~div_by_zero_s;
                            cnt_s     = DIV_LOAD;
                            state_s   = ST_BUSY;
                            busy_s    = 1'b1;
                        end
                        MDUOP_MTHI: hi_s = operand1;
                        MDUOP_MTLO: lo_s = operand1;
                        default: begin
                            state_s = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // Starts arriving here are protocol violations and ignored.
                if (cnt_r == CNT_ONE) begin
                    if (pend_we_r) begin
                        hi_s = pend_hi_r;
                        lo_s = pend_lo_r;
                    end else begin
                        hi_s = hi_r;
                    end
                    pend_we_s = 1'b0;
                    cnt_s     = CNT_ZERO;
                    state_s   = ST_IDLE;
                    busy_s    = 1'b0;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                cnt_s     = CNT_ZERO;
                busy_s    = 1'b0;
                pend_we_s = 1'b0;
            end
        endcase
    end

    // State, counter, pending result and architectural HI/LO registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            busy_r    <= 1'b0;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            pend_hi_r <= 32'd0;
            pend_lo_r <= 32'd0;
            pend_we_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            busy_r    <= busy_s;
            hi_r      <= hi_s;
            lo_r      <= lo_s;
            pend_hi_r <= pend_hi_s;
            pend_lo_r <= pend_lo_s;
            pend_we_r <= pend_we_s;
        end
    end

    assign busy = busy_r;

    // Combinational HI/LO read for mfhi/mflo; everything else reads zero.
    always_comb begin
        result = 32'd0;
        case (operation)
            MDUOP_MFHI: result = hi_r;
            MDUOP_MFLO: result = lo_r;
            default:    result = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: a vector table replayed through a
// scoreboard queue, plus hand-written busy-start and reset-abort sequences.
module tb_mdu;
    import mdu_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [3:0]  operation;
    logic        start;
    logic        busy;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .operand1  (operand1),
        .operand2  (operand2),
        .operation (operation),
        .start     (start),
        .busy      (busy),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
        operation = MDUOP_MFHI;
        #1;
        hi = result;
        operation = MDUOP_MFLO;
        #1;
        lo = result;
        operation = MDUOP_NONE;
    endtask

    // Drive a one-cycle start pulse and record what the unit must produce.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] hi, input logic [31:0] lo, input int cycles);
        exp_t e;
        e.hi = hi;
        e.lo = lo;
        e.cycles = cycles;
        sb.push_back(e);
        @(negedge clk);
        operation = op;
        operand1  = a;
        operand2  = b;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        operation = MDUOP_NONE;
    endtask

    // Count remaining busy cycles (bounded), then compare against the scoreboard.
    task automatic complete(input string name);
        int          n;
        exp_t        e;
        logic [31:0] hi;
        logic [31:0] lo;
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            n++;
            @(negedge clk);
        end
        e = sb.pop_front();
        check32({name, "_busy_cycles"}, 32'(n), 32'(e.cycles));
        read_hilo(hi, lo);
        check32({name, "_hi"}, hi, e.hi);
        check32({name, "_lo"}, lo, e.lo);
    endtask

    initial begin
        logic [31:0] hi;
        logic [31:0] lo;

        reset     = 1'b1;
        operand1  = 32'd0;
        operand2  = 32'd0;
        operation = MDUOP_NONE;
        start     = 1'b0;

        vecs.push_back('{MDUOP_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 5});
        vecs.push_back('{MDUOP_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10});
        vecs.push_back('{MDUOP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10});
        vecs.push_back('{MDUOP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10});
        vecs.push_back('{MDUOP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5});
        vecs.push_back('{MDUOP_MULT,  32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 5});
        vecs.push_back('{MDUOP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10});
        vecs.push_back('{MDUOP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 10});
        vecs.push_back('{MDUOP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5});
        vecs.push_back('{MDUOP_MTHI,  32'h12345678, 32'h0,        32'h12345678, 32'h00000000, 0});
        vecs.push_back('{MDUOP_MTLO,  32'h9ABCDEF0, 32'h0,        32'h12345678, 32'h9ABCDEF0, 0});
        vecs.push_back('{MDUOP_MTHI,  32'h00000005, 32'h0,        32'h00000005, 32'h9ABCDEF0, 0});
        vecs.push_back('{MDUOP_MTLO,  32'h00000006, 32'h0,        32'h00000005, 32'h00000006, 0});
        vecs.push_back('{MDUOP_DIV,   32'h00000009, 32'h00000000, 32'h00000005, 32'h00000006, 10});
        vecs.push_back('{MDUOP_DIVU,  32'hFFFFFFFF, 32'h00000000, 32'h00000005, 32'h00000006, 10});
        vecs.push_back('{4'hF,        32'hDEADBEEF, 32'h00000001, 32'h00000005, 32'h00000006, 0});

        // Reset state.
        #2;
        check32("reset_busy", {31'd0, busy}, 32'd0);
        read_hilo(hi, lo);
        check32("reset_hi", hi, 32'd0);
        check32("reset_lo", lo, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Table-driven operations.
        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].cycles);
            complete($sformatf("vec%0d", i));
        end

        // Non-read operation codes must not expose HI/LO.
        operation = MDUOP_NONE;
        #1;
        check32("result_none", result, 32'd0);
        operation = 4'hE;
        #1;
        check32("result_undef", result, 32'd0);
        operation = MDUOP_NONE;

        // Start while busy is ignored; reads during busy return old HI/LO.
        // Counting resumes one cycle later, so four busy cycles remain.
        issue(MDUOP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 4);
        read_hilo(hi, lo);
        check32("busy_read_hi", hi, 32'h00000005);
        check32("busy_read_lo", lo, 32'h00000006);
        operation = MDUOP_MTHI;
        operand1  = 32'h00000001;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        operation = MDUOP_NONE;
        complete("start_while_busy");

        // Reset in the middle of a divide aborts it without an update.
        issue(MDUOP_MTHI, 32'h0, 32'h0, 32'h0, 32'h00000001, 0);
        complete("clear_hi");
        issue(MDUOP_MTLO, 32'h0, 32'h0, 32'h0, 32'h0, 0);
        complete("clear_lo");
        @(negedge clk);
        operation = MDUOP_DIVU;
        operand1  = 32'd100;
        operand2  = 32'd7;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        operation = MDUOP_NONE;
        check32("abort_busy_before", {31'd0, busy}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check32("abort_busy_async", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        check32("abort_busy_after", {31'd0, busy}, 32'd0);
        read_hilo(hi, lo);
        check32("abort_hi", hi, 32'd0);
        check32("abort_lo", lo, 32'd0);
        issue(MDUOP_MULT, 32'd3, 32'd4, 32'd0, 32'd12, 5);
        complete("after_abort_mult");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
